// File: rtl/piso_serializer.sv
// Purpose: parallel-in/serial-out transmitter, WIDTH-bit word in over valid/ready, one bit out per shift_en_i strobe.
// Latency: handshake at edge N puts bit 0 on ser_o in cycle N+1; a frame lasts exactly WIDTH strobed edges.
// Backpressure: ready_o only in IDLE or on the final strobed bit of a frame (back-to-back loads, no gap).
//
// Ports:
//   clk, reset        - clock; asynchronous active-low reset (clears state, gates ready_o)
//   data_i, valid_i   - producer word and valid; data_i sampled only on handshake
//   ready_o           - word accepted on this edge if valid_i=1 (combinational from shift_en_i)
//   shift_en_i        - bit-advance strobe; current bit consumed on an edge where it is 1
//   ser_o             - serial bit (0 when idle)
//   ser_valid_o       - ser_o carries a frame bit
//   first_o, last_o   - ser_o is the first / final bit of the frame
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             shift_en_i,
    output logic             ser_o,
    output logic             ser_valid_o,
    output logic             first_o,
    output logic             last_o
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_load;
    logic             w_at_end;
    logic             w_hs;

    // The shifter always emits sreg[0], so MSB-first is handled by
    // reversing the word once at load time.
    always_comb begin
        w_load = data_i;
        if (!LSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_load[i] = data_i[WIDTH-1-i];
            end
        end
    end

    assign w_at_end = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);

    // Reset gates ready_o so nothing is offered while the block is held.
    assign ready_o = reset && ((r_state == S_IDLE) || (w_at_end && shift_en_i));
    assign w_hs    = valid_i && ready_o;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_sreg_nxt  = w_load;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shift_en_i) begin
                    if (r_cnt == CNT_LAST) begin
                        // Frame end: chain straight into the next word if one is offered.
                        if (w_hs) begin
                            w_sreg_nxt = w_load;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_sreg_nxt = r_sreg >> 1;
                        w_cnt_nxt  = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Serial outputs decode from registers only.
    assign ser_valid_o = (r_state == S_SHIFT);
    assign ser_o       = ser_valid_o && r_sreg[0];
    assign first_o     = ser_valid_o && (r_cnt == '0);
    assign last_o      = w_at_end;

endmodule

// File: tb/tb_piso_serializer.sv
// Purpose: self-checking bench for piso_serializer, LSB-first and MSB-first instances in lockstep.
// Latency: reference model predicts outputs every cycle from word/bit-index arithmetic.
// Backpressure: model expects ready only when idle or on a strobed final bit.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       sen;

    logic ready0, ser0, sv0, first0, last0;
    logic ready1, ser1, sv1, first1, last1;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut0 (
        .clk(clk), .reset(rst_n), .data_i(data), .valid_i(valid), .ready_o(ready0),
        .shift_en_i(sen), .ser_o(ser0), .ser_valid_o(sv0), .first_o(first0), .last_o(last0)
    );

    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(rst_n), .data_i(data), .valid_i(valid), .ready_o(ready1),
        .shift_en_i(sen), .ser_o(ser1), .ser_valid_o(sv1), .first_o(first1), .last_o(last1)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference model: a frame is "word W, currently showing sent-bit number idx".
    logic       m_busy = 1'b0;
    logic [7:0] m_word = 8'h00;
    int         m_idx  = 0;
    int         nacc   = 0;
    int         nrx    = 0;

    // Received frames, packed with the i-th transmitted bit at position i.
    logic [7:0] cap0, cap1;
    logic [7:0] f0 = 8'h00, f1 = 8'h00, prev_f0 = 8'h00;

    // Last observed outputs (sampled mid-cycle).
    logic o_rdy0, o_sv0, o_ser0, o_ser1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic model_reset();
        if (m_busy) nacc--;   // aborted frame is never delivered
        m_busy = 1'b0;
        m_idx  = 0;
        cap0   = 8'h00;
        cap1   = 8'h00;
    endtask

    // One clock cycle: drive at negedge, check #1 later, advance model at posedge.
    task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d);
        logic e_rdy, e_ser0, e_ser1, e_first, e_last;
        @(negedge clk);
        rst_n = r; valid = v; sen = s; data = d;
        if (!r) model_reset();
        #1;
        e_rdy   = r && (!m_busy || (s && m_idx == 7));
        e_ser0  = m_busy ? m_word[m_idx]     : 1'b0;
        e_ser1  = m_busy ? m_word[7 - m_idx] : 1'b0;
        e_first = m_busy && (m_idx == 0);
        e_last  = m_busy && (m_idx == 7);
        o_rdy0 = ready0; o_sv0 = sv0; o_ser0 = ser0; o_ser1 = ser1;
        check("ready0", ready0, e_rdy);
        check("ready1", ready1, e_rdy);
        check("ser_valid0", sv0, m_busy);
        check("ser_valid1", sv1, m_busy);
        check("ser0", ser0, e_ser0);
        check("ser1", ser1, e_ser1);
        check("first0", first0, e_first);
        check("first1", first1, e_first);
        check("last0", last0, e_last);
        check("last1", last1, e_last);
        @(posedge clk);
        if (r && m_busy && s) begin
            cap0[m_idx] = o_ser0;
            cap1[m_idx] = o_ser1;
            if (m_idx == 7) begin
                prev_f0 = f0;
                f0 = cap0;
                f1 = cap1;
                nrx++;
                check("frame_lsb", cap0, m_word);
                check("frame_msb", cap1, rev8(m_word));
            end
        end
        if (e_rdy && v) begin
            m_busy = 1'b1; m_word = d; m_idx = 0; nacc++;
        end else if (r && m_busy && s) begin
            if (m_idx == 7) m_busy = 1'b0;
            else m_idx++;
        end
    endtask

    // Drop reset between edges and confirm outputs clear without a clock.
    task automatic async_rst();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready0", ready0, 1'b0);
        check("arst_sv0", sv0, 1'b0);
        check("arst_ser0", ser0, 1'b0);
        check("arst_first0", first0, 1'b0);
        check("arst_last0", last0, 1'b0);
        check("arst_ready1", ready1, 1'b0);
        check("arst_sv1", sv1, 1'b0);
        model_reset();
    endtask

    int gaps, nrdy;

    initial begin
        rst_n = 1'b0; valid = 1'b0; sen = 1'b0; data = 8'h00;
        #1;
        check("por_ready0", ready0, 1'b0);
        check("por_sv0", sv0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 8'hA5);

        // 8'hA5, shift every cycle
        cyc(1'b1, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("a5_lsb", f0, 8'hA5);
        check("a5_msb", f1, 8'hA5);

        // 8'h0F: LSB-first 1,1,1,1,0,0,0,0; MSB-first 0,0,0,0,1,1,1,1
        cyc(1'b1, 1'b1, 1'b1, 8'h0F);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("0f_lsb", f0, 8'h0F);
        check("0f_msb", f1, 8'hF0);

        // 8'h3C with a strobe every 4th cycle
        cyc(1'b1, 1'b1, 1'b0, 8'h3C);
        nrdy = 0;
        for (int k = 0; k < 32; k++) begin
            cyc(1'b1, 1'b0, (k % 4) == 3, 8'h00);
            if (o_rdy0) nrdy++;
        end
        check("3c_ready_cnt", nrdy, 1);
        check("3c_lsb", f0, 8'h3C);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);

        // Back-to-back 8'h01 then 8'h80 with valid held
        cyc(1'b1, 1'b1, 1'b1, 8'h01);
        gaps = 0; nrdy = 0;
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, k < 8, 1'b1, 8'h80);
            if (!o_sv0) gaps++;
            if (o_rdy0) nrdy++;
        end
        check("b2b_gaps", gaps, 0);
        check("b2b_ready_cnt", nrdy, 2);
        check("b2b_word1", prev_f0, 8'h01);
        check("b2b_word2", f0, 8'h80);
        cyc(1'b1, 1'b0, 1'b1, 8'h00);

        // Reset mid-frame at bit 3 of 8'hFF, then send 8'h00
        cyc(1'b1, 1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        async_rst();
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("zero_frame", f0, 8'h00);
        check("frames_after_abort", nrx, nacc);

        // Random: toggling valid/data mid-frame, random strobes, rare resets
        for (int k = 0; k < 2000; k++) begin
            cyc(($urandom % 300) != 0, $urandom % 2, ($urandom % 3) != 0, 8'($urandom));
        end
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, 8'h00);
        check("frames_total", nrx, nacc);
        check("idle_end_sv0", sv0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
